esl_dot_product_pe: RTL and testbench

- Parametrised multi-input ESL (extended stochastic logic) processing element for neural-network layers; the next generation of the single-input PE.
- Multiplies NUM_IN ESL input stream pairs by NUM_IN binary weights and forms a scaled sum with a chained init stream.
- Runs over a fixed evaluation window under a start/done handshake, counting ones on both output rails.
- Chains PE-to-PE through output_val_x/y; count_x/count_y feed the layer's stochastic-to-binary readout.

---
 rtl/esl_pkg.sv | 38 +++
 rtl/esl_sng_lfsr.sv | 37 +++
 rtl/esl_dot_product_pe.sv | 146 ++++++++++++++
 tb/tb_esl_dot_product_pe.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/esl_pkg.sv
// Shared types and constants for the ESL dot-product processing element:
// FSM states, maximal-length LFSR tap masks and the ones-counter width helper.
package esl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int LFSR_MIN_WIDTH = 4;
    localparam int LFSR_MAX_WIDTH = 16;

    // Fibonacci feedback masks: bit (p-1) set for each tap position p.
    function automatic logic [15:0] lfsr_taps(input int width);
        case (width)
            4:       lfsr_taps = 16'h000C;
            5:       lfsr_taps = 16'h0014;
            6:       lfsr_taps = 16'h0030;
            7:       lfsr_taps = 16'h0060;
            8:       lfsr_taps = 16'h00B8;
            9:       lfsr_taps = 16'h0110;
            10:      lfsr_taps = 16'h0240;
            11:      lfsr_taps = 16'h0500;
            12:      lfsr_taps = 16'h0829;
            13:      lfsr_taps = 16'h100D;
            14:      lfsr_taps = 16'h2015;
            15:      lfsr_taps = 16'h6000;
            16:      lfsr_taps = 16'hD008;
            default: lfsr_taps = 16'h00B8;
        endcase
    endfunction

    function automatic int cnt_width(input int stream_len);
        return $clog2(stream_len + 1);
    endfunction

endpackage

// File: rtl/esl_sng_lfsr.sv
// Stochastic number generator for one channel: an LFSR compared against a
// binary weight, producing a bit that is 1 with probability weight/2^BIN_LEN.
module esl_sng_lfsr
    import esl_pkg::*;
#(
    parameter int                 BIN_LEN = 8,
    parameter logic [BIN_LEN-1:0] SEED    = BIN_LEN'(1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               advance,
    input  logic [BIN_LEN-1:0] in_val,
    output logic               out_val
);

    localparam logic [15:0] TAPS = lfsr_taps(BIN_LEN);

    logic [BIN_LEN-1:0] lfsr;
    logic               feedback;

    assign feedback = ^(lfsr & TAPS[BIN_LEN-1:0]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr <= '0;
        end else if (load) begin
            lfsr <= SEED;
        end else if (advance) begin
            lfsr <= {lfsr[BIN_LEN-2:0], feedback};
        end
    end

    // The LFSR never reaches zero once seeded, so a zero weight yields constant 0.
    assign out_val = (lfsr < in_val);

endmodule

// File: rtl/esl_dot_product_pe.sv
// Multi-input ESL processing element: NUM_IN weighted products plus a chained
// init stream, combined by a counter-selected scaled sum over a fixed window.
module esl_dot_product_pe
    import esl_pkg::*;
#(
    parameter int BIN_LEN    = 8,
    parameter int NUM_IN     = 4,
    parameter int STREAM_LEN = 256
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                enable,
    input  logic                                start,
    input  logic                                clear,
    input  logic [NUM_IN*BIN_LEN-1:0]           weight_val,
    input  logic [NUM_IN-1:0]                   input_val_x,
    input  logic [NUM_IN-1:0]                   input_val_y,
    input  logic                                init_val_x,
    input  logic                                init_val_y,
    output logic                                output_val_x,
    output logic                                output_val_y,
    output logic                                stream_valid,
    output logic                                busy,
    output logic                                done,
    output logic [cnt_width(STREAM_LEN)-1:0]    count_x,
    output logic [cnt_width(STREAM_LEN)-1:0]    count_y
);

    localparam int CNT_W = cnt_width(STREAM_LEN);
    localparam int CYC_W = (STREAM_LEN > 1) ? $clog2(STREAM_LEN) : 1;
    localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    if (NUM_IN < 1 || (NUM_IN & (NUM_IN - 1)) != 0) begin : g_bad_num_in
        $error("esl_dot_product_pe: NUM_IN must be a power of two");
    end
    if (STREAM_LEN % (2 * NUM_IN) != 0) begin : g_bad_stream_len
        $error("esl_dot_product_pe: STREAM_LEN must be a multiple of 2*NUM_IN");
    end
    if (BIN_LEN < LFSR_MIN_WIDTH || BIN_LEN > LFSR_MAX_WIDTH) begin : g_bad_bin_len
        $error("esl_dot_product_pe: BIN_LEN must be within 4..16");
    end

    state_t                      state;
    logic [CYC_W-1:0]            cyc;
    logic [NUM_IN*BIN_LEN-1:0]   weight_q;
    logic [NUM_IN-1:0]           w_x;
    logic [NUM_IN-1:0]           p_x;
    logic [NUM_IN-1:0]           p_y;
    logic [SEL_W-1:0]            k;
    logic                        accept;
    logic                        sel_x;
    logic                        sel_y;

    assign accept       = (state == IDLE) && start && enable && !clear;
    assign stream_valid = busy && enable;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_sng
        esl_sng_lfsr #(
            .BIN_LEN (BIN_LEN),
            .SEED    (BIN_LEN'(i + 1))
        ) u_sng (
            .clock   (clock),
            .reset   (reset),
            .load    (accept),
            .advance (stream_valid),
            .in_val  (weight_q[i*BIN_LEN +: BIN_LEN]),
            .out_val (w_x[i])
        );
    end

    // XNOR multiplies the numerators; the weight denominator is always 1.
    assign p_x = ~(w_x ^ input_val_x);
    assign p_y = input_val_y;

    if (NUM_IN == 1) begin : g_sel_single
        assign k = '0;
    end else begin : g_sel_multi
        assign k = cyc[SEL_W:1];
    end

    always_comb begin
        sel_x = 1'b0;
        sel_y = 1'b0;
        if (cyc[0]) begin
            sel_x = init_val_x;
            sel_y = init_val_y;
        end else begin
            sel_x = p_x[k];
            sel_y = p_y[k];
        end
        output_val_x = stream_valid && sel_x;
        output_val_y = stream_valid && sel_y;
    end

    // DONE lasts exactly one cycle regardless of enable; clear wins over everything.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cyc      <= '0;
            weight_q <= '0;
            count_x  <= '0;
            count_y  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            state    <= RUN;
                            busy     <= 1'b1;
                            cyc      <= '0;
                            weight_q <= weight_val;
                            count_x  <= '0;
                            count_y  <= '0;
                        end
                    end
                    RUN: begin
                        if (enable) begin
                            count_x <= count_x + CNT_W'(output_val_x);
                            count_y <= count_y + CNT_W'(output_val_y);
                            cyc     <= cyc + 1'b1;
                            if (cyc == CYC_W'(STREAM_LEN - 1)) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_esl_dot_product_pe.sv
// Self-checking bench for esl_dot_product_pe: table-driven windows plus
// hand-written clear, reset and stall sequences.
module tb_esl_dot_product_pe;
    import esl_pkg::*;

    localparam int BIN_LEN    = 8;
    localparam int NUM_IN     = 4;
    localparam int STREAM_LEN = 256;
    localparam int CW         = $clog2(STREAM_LEN + 1);
    localparam int MAX_CYCLES = 400;

    logic                        clock = 1'b0;
    logic                        reset = 1'b0;
    logic                        enable = 1'b0;
    logic                        start = 1'b0;
    logic                        clear = 1'b0;
    logic [NUM_IN*BIN_LEN-1:0]   weight_val = '0;
    logic [NUM_IN-1:0]           input_val_x = '0;
    logic [NUM_IN-1:0]           input_val_y = '0;
    logic                        init_val_x = 1'b0;
    logic                        init_val_y = 1'b0;
    logic                        output_val_x;
    logic                        output_val_y;
    logic                        stream_valid;
    logic                        busy;
    logic                        done;
    logic [CW-1:0]               count_x;
    logic [CW-1:0]               count_y;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] weights;
        logic [3:0]  in_x;
        logic [3:0]  in_y;
        logic        init_x;
        logic        init_y;
        int          stall_len;
        int          extra_start;
        int          exp_x;
        int          exp_y;
    } vec_t;

    vec_t vecs[8];

    esl_dot_product_pe #(
        .BIN_LEN    (BIN_LEN),
        .NUM_IN     (NUM_IN),
        .STREAM_LEN (STREAM_LEN)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .start        (start),
        .clear        (clear),
        .weight_val   (weight_val),
        .input_val_x  (input_val_x),
        .input_val_y  (input_val_y),
        .init_val_x   (init_val_x),
        .init_val_y   (init_val_y),
        .output_val_x (output_val_x),
        .output_val_y (output_val_y),
        .stream_valid (stream_valid),
        .busy         (busy),
        .done         (done),
        .count_x      (count_x),
        .count_y      (count_y)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference for the x rail: steps each channel's SNG through the window.
    function automatic int model_count_x(input logic [31:0] w, input logic [3:0] in_x, input logic init_x);
        logic [15:0] taps16;
        logic [7:0]  taps;
        logic [7:0]  lfsr[4];
        int          cnt;
        int          kk;
        logic        b;
        taps16 = lfsr_taps(BIN_LEN);
        taps   = taps16[7:0];
        cnt    = 0;
        for (int i = 0; i < 4; i++) lfsr[i] = 8'(i + 1);
        for (int c = 0; c < STREAM_LEN; c++) begin
            if (c % 2 == 1) begin
                b = init_x;
            end else begin
                kk = (c / 2) % 4;
                b  = ~((lfsr[kk] < w[kk*8 +: 8]) ^ in_x[kk]);
            end
            cnt += int'(b);
            for (int i = 0; i < 4; i++) lfsr[i] = {lfsr[i][6:0], ^(lfsr[i] & taps)};
        end
        return cnt;
    endfunction

    task automatic drive_inputs(input vec_t v);
        weight_val  = v.weights;
        input_val_x = v.in_x;
        input_val_y = v.in_y;
        init_val_x  = v.init_x;
        init_val_y  = v.init_y;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int   done_at;
        int   valid_seen;
        int   ones_x;
        int   ones_y;
        drive_inputs(v);
        @(posedge clock); #1;
        start  = 1'b1;
        enable = 1'b1;
        @(posedge clock); #1;
        start      = 1'b0;
        done_at    = 0;
        valid_seen = 0;
        ones_x     = 0;
        ones_y     = 0;
        for (int n = 1; n <= MAX_CYCLES; n++) begin
            enable = !(n > 100 && n <= 100 + v.stall_len);
            start  = (v.extra_start != 0 && n == v.extra_start);
            @(negedge clock);
            if (stream_valid) begin
                valid_seen++;
                ones_x += int'(output_val_x);
                ones_y += int'(output_val_y);
            end
            if (done) begin
                done_at = n;
                break;
            end
            @(posedge clock); #1;
        end
        enable = 1'b1;
        start  = 1'b0;
        checkOutput($sformatf("v%0d done_cycle", idx), done_at, STREAM_LEN + 1 + v.stall_len);
        checkOutput($sformatf("v%0d valid_cycles", idx), valid_seen, STREAM_LEN);
        checkOutput($sformatf("v%0d ones_x", idx), ones_x, v.exp_x);
        checkOutput($sformatf("v%0d ones_y", idx), ones_y, v.exp_y);
        checkOutput($sformatf("v%0d count_x", idx), count_x, v.exp_x);
        checkOutput($sformatf("v%0d count_y", idx), count_y, v.exp_y);
        @(posedge clock); #1;
        @(negedge clock);
        checkOutput($sformatf("v%0d done_after", idx), done, 0);
        checkOutput($sformatf("v%0d busy_after", idx), busy, 0);
    endtask

    task automatic clear_sequence();
        int done_seen;
        drive_inputs(vecs[0]);
        @(posedge clock); #1;
        start  = 1'b1;
        enable = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int n = 1; n <= 101; n++) begin
            clear = (n == 101);
            @(negedge clock);
            if (n < 101) begin
                @(posedge clock); #1;
            end
        end
        @(posedge clock); #1;
        clear = 1'b0;
        @(negedge clock);
        checkOutput("clear busy", busy, 0);
        checkOutput("clear done", done, 0);
        checkOutput("clear stream_valid", stream_valid, 0);
        checkOutput("clear partial count_x", count_x, 50);
        checkOutput("clear partial count_y", count_y, 100);
        done_seen = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            if (done) done_seen++;
        end
        checkOutput("clear no_done", done_seen, 0);
    endtask

    task automatic reset_sequence();
        drive_inputs(vecs[0]);
        @(posedge clock); #1;
        start  = 1'b1;
        enable = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (50) @(posedge clock);
        #1;
        reset = 1'b0;
        #2;
        checkOutput("async_reset output_val_y", output_val_y, 0);
        checkOutput("async_reset stream_valid", stream_valid, 0);
        checkOutput("async_reset busy", busy, 0);
        checkOutput("async_reset count_y", count_y, 0);
        checkOutput("async_reset count_x", count_x, 0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 0, 0, 128, 256};
        vecs[1] = '{32'h0000_0000, 4'b1111, 4'b1111, 1'b1, 1'b1, 0, 0, 128, 256};
        vecs[2] = '{32'h0000_0000, 4'b1110, 4'b1111, 1'b0, 1'b1, 0, 0, 32, 256};
        vecs[3] = '{32'h0000_0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 10, 0, 128, 256};
        vecs[4] = '{32'h0000_0000, 4'b0000, 4'b0101, 1'b1, 1'b0, 0, 0, 256, 64};
        vecs[5] = '{32'h0000_0000, 4'b0101, 4'b0011, 1'b0, 1'b1, 0, 0, 64, 192};
        vecs[6] = '{32'h0000_0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 0, 20, 128, 256};
        vecs[7] = '{32'h0140_80FF, 4'b1111, 4'b1111, 1'b0, 1'b1, 0, 0, 0, 256};
        vecs[7].exp_x = model_count_x(vecs[7].weights, vecs[7].in_x, vecs[7].init_x);

        #2;
        checkOutput("reset output_val_x", output_val_x, 0);
        checkOutput("reset stream_valid", stream_valid, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset counts", {count_x, count_y}, 0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

        clear_sequence();
        applyStimulus(vecs[0], 100);

        reset_sequence();
        applyStimulus(vecs[0], 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
